// File: rtl/regfile_dump_if.sv
// Output stream of the register-file dump engine: one snapshot word per
// transfer, tagged with its register index and an end-of-range marker.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;
  logic [ADDR_W-1:0] outIndex;
  logic              outLast;

  modport master (
    output outValid,
    output outData,
    output outIndex,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    input  outIndex,
    input  outLast,
    output outReady
  );
endinterface

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register range through a dedicated register
// file read port, snapshots each value, and streams it out with its index.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] firstReg,
  input  logic [ADDR_W-1:0] lastReg,
  output logic [ADDR_W-1:0] rfReadRegister,
  input  logic [DATA_W-1:0] rfReadData,
  regfile_dump_if.master    out,
  output logic              busy,
  output logic              done,
  output logic              rangeErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] curIdx_q, curIdx_d;
  logic [ADDR_W-1:0] endIdx_q, endIdx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              handshake;

  assign handshake = (state_q == S_HOLD) && out.outReady;

  // State register; reset aborts any dump in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one READ cycle per word, HOLD until accepted, DONE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (firstReg <= lastReg) ? S_READ : S_DONE;
      S_READ: state_d = S_HOLD;
      S_HOLD: if (out.outReady) state_d = last_q ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: range latch, snapshot capture, index advance.
  always_comb begin
    curIdx_d = curIdx_q;
    endIdx_d = endIdx_q;
    data_d   = data_q;
    index_d  = index_q;
    last_d   = last_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          curIdx_d = firstReg;
          endIdx_d = lastReg;
          err_d    = (firstReg > lastReg);
        end
      end
      S_READ: begin
        // Snapshot taken from the pre-edge read data, so a same-cycle write
        // or any later write cannot disturb the word being presented.
        data_d  = rfReadData;
        index_d = curIdx_q;
        last_d  = (curIdx_q == endIdx_q);
      end
      S_HOLD: begin
        // Advance only when not last, so an end index of all-ones never wraps.
        if (handshake && !last_q) curIdx_d = curIdx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared on reset so outputs return to known values.
  always_ff @(posedge clk) begin
    if (reset) begin
      curIdx_q <= '0;
      endIdx_q <= '0;
      data_q   <= '0;
      index_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      curIdx_q <= curIdx_d;
      endIdx_q <= endIdx_d;
      data_q   <= data_d;
      index_q  <= index_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state; the read port idles at index 0.
  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    rangeErr       = (state_q == S_DONE) && err_q;
    out.outValid   = (state_q == S_HOLD);
    rfReadRegister = ((state_q == S_READ) || (state_q == S_HOLD)) ? curIdx_q : '0;
    out.outData    = data_q;
    out.outIndex   = index_q;
    out.outLast    = last_q;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the MIPS register file. On a start pulse it walks a programmed register range through one of the register file's read ports, snapshots each value, and streams it out over a valid/ready interface tagged with its register index. It sits beside the datapath's `RegisterFile`, owning a dedicated read port, so the core's two read ports and the write port are untouched.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width (32 registers)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE
- `firstReg`  in  ADDR_W  first register index; sampled with `start`
- `lastReg`  in  ADDR_W  last register index, inclusive; sampled with `start`
- `rfReadRegister`  out  ADDR_W  address to register file read port
- `rfReadData`  in  DATA_W  combinational read data returned for `rfReadRegister`
- `outValid`  out  1  `outData`/`outIndex`/`outLast` valid
- `outReady`  in  1  downstream accepts word when high with `outValid`
- `outData`  out  DATA_W  captured register value
- `outIndex`  out  ADDR_W  index of the register in `outData`
- `outLast`  out  1  high with the final word of the range
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse at end of a dump
- `rangeErr`  out  1  one-cycle pulse, coincident with `done`, when `firstReg > lastReg`

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: `rfReadRegister`=0, `outValid`=0. On `start`=1: latch `lastReg` into `endIdx`, `firstReg` into `curIdx`. If `firstReg <= lastReg` (unsigned) go READ; else go DONE with `rangeErr` set.
- READ (one cycle): `rfReadRegister`=`curIdx`; at the edge capture `rfReadData` into `outData`, `curIdx` into `outIndex`, `outLast` = (`curIdx`==`endIdx`); set `outValid`; go HOLD.
- HOLD: `outValid`=1; `outData`, `outIndex`, `outLast` held stable until handshake, independent of later register-file writes (value is a snapshot). On `outValid && outReady`: if `outLast` go DONE, else `curIdx` += 1, go READ. `rfReadRegister` holds `curIdx` in HOLD.
- DONE (one cycle): `done`=1 (`rangeErr`=1 if entered on range error), `outValid`=0; go IDLE.
- `start` outside IDLE is ignored; ranges are not queued.
- Index 0 is read like any other; the register file returns 0, so the word is emitted as 0.
- `curIdx` never wraps: `lastReg`=31 terminates on `outLast`, before the increment.
- Register file writes in the same cycle as READ: the captured value is whatever `rfReadData` shows during READ, i.e. the pre-edge contents.

## Timing
- Reset: state IDLE; `outValid`, `outLast`, `busy`, `done`, `rangeErr` = 0; `outData`=0, `outIndex`=0, `rfReadRegister`=0. Reset mid-dump aborts immediately: no `done` pulse, the in-flight word is dropped.
- `start` sampled at edge E: READ during cycle E+1; first `outValid` high in cycle E+2.
- Each word costs 2 cycles minimum (READ + HOLD) with `outReady` held high; N words → `done` in cycle E+2N+1 after `start` edge E.
- `outReady` low stalls in HOLD indefinitely; no outputs change while stalled.
- `busy` high from E+1 through the DONE cycle inclusive; a new `start` is accepted in the first IDLE cycle after DONE.
- Range error: DONE in cycle E+1 with `done`=`rangeErr`=1, no `outValid`.

## Test plan
- Preload r1..r3 = 0x11111111, 0x22222222, 0x33333333; start first=1,last=3, `outReady`=1 → three words idx 1,2,3 with those values, `outLast` only on idx 3, `done` in cycle E+7.
- first=0,last=0 → single word idx 0, data 0x00000000, `outLast`=1, then `done`.
- first=30,last=31 with `outReady` toggling 0/1 randomly → words stable while stalled, exactly two handshakes, no index past 31.
- first=5,last=4 → no `outValid`; `done`=`rangeErr`=1 in cycle E+1; `busy` high for one cycle only.
- Write r2 := 0xDEADBEEF while word r2 is in HOLD → emitted `outData` remains the old snapshot; re-dump shows 0xDEADBEEF.
- Assert `reset` while in HOLD mid-range → next cycle all outputs at reset values, no `done`; `start` pulsed during busy → ignored.
